io_handshake_unit: RTL and testbench



---
 rtl/io_handshake_pkg.sv | 13 +
 rtl/key_debouncer.sv | 45 ++++
 rtl/io_handshake_unit.sv | 63 ++++++
 tb/tb_io_handshake_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_handshake_pkg.sv
// io_handshake_pkg: shared encodings for the operator I/O handshake.
//   io_state_e    : FSM state as shown on the debug display
//   req_class_e   : which operator key serves the current request
//   classify()    : maps control-core feedback to a request class
package io_handshake_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} io_state_e;
  typedef enum logic [1:0] {NONE = 2'd0, CONFIRM = 2'd1, CONTINUE = 2'd2} req_class_e;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  // PAUSE raises both flags and is served by the continue key; a lone flag is INPUT/OUTPUT.
  function automatic req_class_e classify(input logic is_in, input logic is_out);
    return (is_in & is_out) ? CONTINUE : (is_in | is_out) ? CONFIRM : NONE;
  endfunction
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: synchronise, debounce and edge-detect one raw board key.
//   clock        : system clock
//   reset        : asynchronous active-low reset
//   raw_key_i    : asynchronous key from the board
//   press_edge_o : one-cycle strobe when the debounced level becomes pressed
module key_debouncer
  import io_handshake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_key_i,
  output logic press_edge_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEBOUNCE_CYCLES);
  logic pressed, differ, done, edge_d, edge_q, level_q, level_d;
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0] cnt_inc;
  assign pressed = KEY_ACTIVE_LOW ? ~raw_key_i : raw_key_i;
  assign differ = sync_q[1] != level_q;
  assign cnt_inc = {1'b0, cnt_q} + (CW + 1)'(1);
  assign done = differ && cnt_inc == LIMIT;
  assign cnt_d = (differ && !done) ? cnt_inc[CW-1:0] : '0;
  assign level_d = level_q ^ done;
  // Only a released-to-pressed toggle strobes; releases just re-arm the key.
  assign edge_d = done & ~level_q;
  assign press_edge_o = edge_q;
  // Level starts as pressed so a key held through reset must be released before it counts.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b1;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pressed};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      edge_q  <= edge_d;
    end
endmodule

// File: rtl/io_handshake_unit.sv
// io_handshake_unit: turns operator key presses into one-cycle I/O enables.
//   clock, reset                    : clock and asynchronous active-low reset
//   raw_confirm_key/raw_continue_key: raw board keys
//   is_input/is_output              : request feedback from the control core
//   confirmation/continue_button    : one-cycle enables for INPUT/OUTPUT and PAUSE
//   waiting                         : request pending (operator LED)
//   io_state                        : FSM state for debug display
module io_handshake_unit
  import io_handshake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_confirm_key,
  input  logic       raw_continue_key,
  input  logic       is_input,
  input  logic       is_output,
  output logic       confirmation,
  output logic       continue_button,
  output logic       waiting,
  output logic [1:0] io_state
);
  logic confirm_edge, continue_edge, hit;
  logic confirmation_q, continue_q, waiting_q;
  req_class_e req;
  io_state_e state_q, state_d;
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)) u_confirm (
    .clock(clock), .reset(reset), .raw_key_i(raw_confirm_key), .press_edge_o(confirm_edge)
  );
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)) u_continue (
    .clock(clock), .reset(reset), .raw_key_i(raw_continue_key), .press_edge_o(continue_edge)
  );
  assign req = classify(is_input, is_output);
  assign hit = (req == CONFIRM && confirm_edge) || (req == CONTINUE && continue_edge);
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = req != NONE ? WAIT : IDLE;
      WAIT:    state_d = req == NONE ? IDLE : hit ? ACK : WAIT;
      ACK:     state_d = req != NONE ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // ACK is only entered from WAIT on a matching press, so the class seen on that edge picks the pulse.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q        <= IDLE;
      waiting_q      <= 1'b0;
      confirmation_q <= 1'b0;
      continue_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      waiting_q      <= state_d == WAIT;
      confirmation_q <= state_d == ACK && req == CONFIRM;
      continue_q     <= state_d == ACK && req == CONTINUE;
    end
  assign confirmation = confirmation_q;
  assign continue_button = continue_q;
  assign waiting = waiting_q;
  assign io_state = state_q;
endmodule

// File: tb/tb_io_handshake_unit.sv
// tb_io_handshake_unit: directed and random stimulus checked against a behavioural model.
module tb_io_handshake_unit;
  localparam int N = 4;
  logic clock, reset, raw_confirm_key, raw_continue_key, is_input, is_output;
  logic confirmation, continue_button, waiting;
  logic [1:0] io_state;
  int checks = 0, errors = 0, cyc = 0, cc = 0, kc = 0;
  bit armed = 0;
  bit lvl [2];
  bit strobe [2];
  bit dl [2][2];
  bit win [2][N];
  bit m_wait, m_conf, m_cont;
  int m_state;

  io_handshake_unit #(.DEBOUNCE_CYCLES(N), .KEY_ACTIVE_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .raw_confirm_key(raw_confirm_key), .raw_continue_key(raw_continue_key),
    .is_input(is_input), .is_output(is_output), .confirmation(confirmation),
    .continue_button(continue_button), .waiting(waiting), .io_state(io_state)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      lvl[k] = 1; strobe[k] = 0; dl[k][0] = 0; dl[k][1] = 0;
      for (int i = 0; i < N; i++) win[k][i] = 1;
    end
    m_wait = 0; m_conf = 0; m_cont = 0; m_state = 0; cyc = 0;
  endtask

  // Key model: a key's sample is its value two edges ago; the level flips once the
  // last N samples all disagree with it. Handshake: a pulse needs a pending request
  // plus a fresh press of the key that serves the request class.
  task automatic model_step();
    int req;
    bit pulse, s, all_diff;
    bit now [2];
    now[0] = !raw_confirm_key;
    now[1] = !raw_continue_key;
    req = (is_input && is_output) ? 2 : (is_input || is_output) ? 1 : 0;
    pulse = m_wait && (req == 1 ? strobe[0] : req == 2 ? strobe[1] : 1'b0);
    m_conf = pulse && req == 1;
    m_cont = pulse && req == 2;
    m_wait = req != 0 && !pulse;
    m_state = pulse ? 2 : m_wait ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      s = dl[k][1];
      dl[k][1] = dl[k][0];
      dl[k][0] = now[k];
      for (int i = N - 1; i > 0; i--) win[k][i] = win[k][i-1];
      win[k][0] = s;
      all_diff = 1;
      for (int i = 0; i < N; i++) if (win[k][i] == lvl[k]) all_diff = 0;
      strobe[k] = all_diff && !lvl[k];
      if (all_diff) lvl[k] = !lvl[k];
    end
    cyc++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(negedge clock);
    if (armed) begin
      checks++;
      if (confirmation !== m_conf || continue_button !== m_cont || waiting !== m_wait || io_state !== 2'(m_state)) begin
        errors++;
        $display("FAIL model cyc=%0d got conf=%b cont=%b wait=%b st=%0d want conf=%b cont=%b wait=%b st=%0d",
                 cyc, confirmation, continue_button, waiting, io_state, m_conf, m_cont, m_wait, m_state);
      end
    end
  end

  task automatic lit(string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clock);
      if (confirmation === 1'b1) cc++;
      if (continue_button === 1'b1) kc++;
    end
  endtask

  initial begin
    reset = 1; raw_confirm_key = 1; raw_continue_key = 1; is_input = 0; is_output = 0;
    #1 reset = 0;
    repeat (3) @(negedge clock);
    lit("reset_conf", 32'(confirmation), 0);
    lit("reset_cont", 32'(continue_button), 0);
    lit("reset_wait", 32'(waiting), 0);
    lit("reset_state", 32'(io_state), 0);
    reset = 1; armed = 1;
    // basic confirm timing
    tick(10);
    lit("wait_c10", 32'(waiting), 0);
    is_output = 1;
    tick(1);
    lit("wait_c11", 32'(waiting), 1);
    tick(9);
    raw_confirm_key = 0; cc = 0; kc = 0;
    tick(6);
    lit("conf_c26", 32'(confirmation), 0);
    tick(1);
    lit("conf_c27", 32'(confirmation), 1);
    lit("model_conf_c27", 32'(m_conf), 1);
    tick(1);
    lit("conf_c28", 32'(confirmation), 0);
    lit("state_c28", 32'(io_state), 1);
    tick(12);
    raw_confirm_key = 1;
    lit("s1_conf_count", cc, 1);
    lit("s1_cont_count", kc, 0);
    // bounce
    tick(10); cc = 0;
    for (int i = 0; i < 6; i++) begin
      raw_confirm_key = 1'(i % 2);
      tick(2);
    end
    raw_confirm_key = 0;
    lit("bounce_none", cc, 0);
    tick(12);
    lit("bounce_once", cc, 1);
    raw_confirm_key = 1;
    tick(10);
    // pause
    is_input = 1;
    tick(2); cc = 0; kc = 0;
    raw_confirm_key = 0;
    tick(12);
    lit("pause_no_conf", cc, 0);
    lit("pause_wait", 32'(waiting), 1);
    raw_confirm_key = 1;
    tick(10);
    raw_continue_key = 0;
    tick(12);
    lit("pause_cont", kc, 1);
    lit("pause_conf", cc, 0);
    raw_continue_key = 1;
    tick(10);
    is_input = 0; is_output = 0;
    tick(2);
    lit("idle_state", 32'(io_state), 0);
    // back-to-back
    is_output = 1;
    tick(2); cc = 0;
    raw_confirm_key = 0;
    tick(20);
    lit("b2b_one", cc, 1);
    lit("b2b_wait", 32'(io_state), 1);
    tick(10);
    lit("b2b_hold", cc, 1);
    raw_confirm_key = 1;
    tick(8);
    raw_confirm_key = 0;
    tick(10);
    lit("b2b_second", cc, 2);
    raw_confirm_key = 1; is_output = 0;
    tick(10);
    // async reset mid-WAIT with key held through reset
    is_input = 1;
    tick(3);
    lit("s5_wait", 32'(waiting), 1);
    raw_confirm_key = 0;
    #2 reset = 0;
    #1 lit("async_wait", 32'(waiting), 0);
    lit("async_state", 32'(io_state), 0);
    tick(4);
    reset = 1; cc = 0;
    tick(20);
    lit("held_through_reset", cc, 0);
    raw_confirm_key = 1;
    tick(6);
    raw_confirm_key = 0;
    tick(10);
    lit("rearm", cc, 1);
    raw_confirm_key = 1; is_input = 0;
    tick(10);
    // request dropped in WAIT, press in IDLE
    is_input = 1;
    tick(3);
    lit("s6_wait", 32'(waiting), 1);
    is_input = 0;
    tick(1);
    lit("drop_wait", 32'(waiting), 0);
    lit("drop_state", 32'(io_state), 0);
    cc = 0; raw_confirm_key = 0;
    tick(12);
    lit("idle_press", cc, 0);
    raw_confirm_key = 1;
    tick(8);
    // random
    cc = 0; kc = 0;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 7) == 0) raw_confirm_key = ~raw_confirm_key;
      if ($urandom_range(0, 7) == 0) raw_continue_key = ~raw_continue_key;
      if ($urandom_range(0, 15) == 0) {is_input, is_output} = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 0;
        tick(2);
        reset = 1;
      end else tick(1);
    end
    lit("random_pulses_seen", 32'(cc + kc > 0), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
